// File: rtl/if_fetch_stage_if.sv
// Bundles the fetch-stage control, instruction-ROM and IF/ID signals.
// The pipeline drives the master side and the fetch stage takes the slave side.
interface if_fetch_stage_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;
    logic [DATA_W-1:0] if_id_inst;
    logic [ADDR_W-1:0] if_id_pc;
    logic [ADDR_W-1:0] if_id_npc;
    logic              if_id_valid;
    logic [15:0]       fetch_cnt;

    modport master (
        output stall, redirect, redirect_pc, rom_inst,
        input  rom_addr, if_id_inst, if_id_pc, if_id_npc, if_id_valid, fetch_cnt
    );

    modport slave (
        input  stall, redirect, redirect_pc, rom_inst,
        output rom_addr, if_id_inst, if_id_pc, if_id_npc, if_id_valid, fetch_cnt
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register feeding a combinational ROM, plus the IF/ID register.
// Latency: 0 cycles to the ROM address, 1 cycle to IF/ID. Priority: redirect > stall > advance.
// Backpressure: stall freezes PC, IF/ID and the fetch counter.
// Optional macro IF_JUMP_PREDECODE_EN: unconditional jumps redirect the PC at fetch time.
module if_fetch_stage #(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 6'h01
`ifdef IF_JUMP_PREDECODE_EN
    , parameter logic [5:0]      JUMP_OP  = 6'h12
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_stage_if.slave bus
);

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_HOLD,
        ACT_FLUSH
    } act_e;

    act_e              act;
    logic [ADDR_W-1:0] pc_q,   pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] ipc_q,  ipc_d;
    logic [ADDR_W-1:0] npc_q,  npc_d;
    logic              vld_q,  vld_d;
    logic [15:0]       cnt_q,  cnt_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_seq;

    // Wraps naturally at 2^ADDR_W; the IF/ID npc uses the same wrapped value.
    assign pc_inc = pc_q + PC_ONE;

`ifdef IF_JUMP_PREDECODE_EN
    logic jump_hit;
    assign jump_hit = (bus.rom_inst[DATA_W-1 -: 6] == JUMP_OP);
    assign pc_seq   = jump_hit ? bus.rom_inst[ADDR_W-1:0] : pc_inc;
`else
    assign pc_seq   = pc_inc;
`endif

    always_comb begin
        act = ACT_ADVANCE;
        if (bus.redirect) begin
            act = ACT_FLUSH;
        end else if (bus.stall) begin
            act = ACT_HOLD;
        end
    end

    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        ipc_d  = ipc_q;
        npc_d  = npc_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        unique case (act)
            ACT_FLUSH: begin
                // The word fetched this cycle is on the wrong path: drop it as a bubble.
                pc_d   = bus.redirect_pc;
                inst_d = '0;
                ipc_d  = '0;
                npc_d  = '0;
                vld_d  = 1'b0;
            end
            ACT_HOLD: begin
            end
            default: begin
                pc_d   = pc_seq;
                inst_d = bus.rom_inst;
                ipc_d  = pc_q;
                npc_d  = pc_inc;
                vld_d  = 1'b1;
                cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            inst_q <= '0;
            ipc_q  <= '0;
            npc_q  <= '0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
            ipc_q  <= ipc_d;
            npc_q  <= npc_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.if_id_inst  = inst_q;
    assign bus.if_id_pc    = ipc_q;
    assign bus.if_id_npc   = npc_q;
    assign bus.if_id_valid = vld_q;
    assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table for the main flow, hand sequences for
// asynchronous reset, jump handling and fetch-counter saturation.
module tb_if_fetch_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    if_fetch_stage_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    if_fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] rom [64];
    assign bus.rom_inst = rom[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

`ifdef IF_JUMP_PREDECODE_EN
    localparam logic [5:0] JMP_NEXT = 6'h01;
`else
    localparam logic [5:0] JMP_NEXT = 6'h10;
`endif

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [5:0]  rpc;
        logic [5:0]  e_ra;
        logic [31:0] e_inst;
        logic [5:0]  e_pc;
        logic [5:0]  e_npc;
        logic        e_vld;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tv [15];

    function automatic vec_t mk(input logic s, input logic r, input logic [5:0] rp,
                                input logic [5:0] ra, input logic [31:0] inst,
                                input logic [5:0] pc, input logic [5:0] npc,
                                input logic vld, input logic [15:0] cnt);
        vec_t v;
        v.stall = s;   v.redirect = r; v.rpc = rp;
        v.e_ra = ra;   v.e_inst = inst; v.e_pc = pc;
        v.e_npc = npc; v.e_vld = vld;  v.e_cnt = cnt;
        return v;
    endfunction

    function automatic logic [31:0] romv(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] ra, input logic [31:0] inst,
                           input logic [5:0] pc, input logic [5:0] npc, input logic vld,
                           input logic [15:0] cnt);
        chk({tag, ".rom_addr"},    32'(bus.rom_addr),    32'(ra));
        chk({tag, ".if_id_inst"},  bus.if_id_inst,       inst);
        chk({tag, ".if_id_pc"},    32'(bus.if_id_pc),    32'(pc));
        chk({tag, ".if_id_npc"},   32'(bus.if_id_npc),   32'(npc));
        chk({tag, ".if_id_valid"}, 32'(bus.if_id_valid), 32'(vld));
        chk({tag, ".fetch_cnt"},   32'(bus.fetch_cnt),   32'(cnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 64; i++) rom[i] = romv(i);
        rom[6'h00] = 32'h00000000;
        rom[6'h01] = 32'h14001021;
        rom[6'h02] = 32'h042010a6;
        rom[6'h0F] = 32'h48000001;

        //            stall red  rpc    ra     inst          pc     npc    vld cnt
        tv[0]  = mk(0, 0, 6'h00, 6'h02, 32'h14001021, 6'h01, 6'h02, 1, 16'd1);
        tv[1]  = mk(0, 0, 6'h00, 6'h03, 32'h042010a6, 6'h02, 6'h03, 1, 16'd2);
        tv[2]  = mk(1, 0, 6'h00, 6'h03, 32'h042010a6, 6'h02, 6'h03, 1, 16'd2);
        tv[3]  = mk(1, 0, 6'h00, 6'h03, 32'h042010a6, 6'h02, 6'h03, 1, 16'd2);
        tv[4]  = mk(0, 0, 6'h00, 6'h04, romv(3),      6'h03, 6'h04, 1, 16'd3);
        tv[5]  = mk(1, 1, 6'h0B, 6'h0B, 32'h0,        6'h00, 6'h00, 0, 16'd3);
        tv[6]  = mk(0, 0, 6'h00, 6'h0C, romv(11),     6'h0B, 6'h0C, 1, 16'd4);
        tv[7]  = mk(0, 1, 6'h3E, 6'h3E, 32'h0,        6'h00, 6'h00, 0, 16'd4);
        tv[8]  = mk(0, 0, 6'h00, 6'h3F, romv(62),     6'h3E, 6'h3F, 1, 16'd5);
        tv[9]  = mk(0, 0, 6'h00, 6'h00, romv(63),     6'h3F, 6'h00, 1, 16'd6);
        tv[10] = mk(0, 0, 6'h00, 6'h01, 32'h0,        6'h00, 6'h01, 1, 16'd7);
        tv[11] = mk(0, 1, 6'h0C, 6'h0C, 32'h0,        6'h00, 6'h00, 0, 16'd7);
        tv[12] = mk(0, 1, 6'h0C, 6'h0C, 32'h0,        6'h00, 6'h00, 0, 16'd7);
        tv[13] = mk(0, 0, 6'h00, 6'h0D, romv(12),     6'h0C, 6'h0D, 1, 16'd8);
        tv[14] = mk(1, 0, 6'h00, 6'h0D, romv(12),     6'h0C, 6'h0D, 1, 16'd8);

        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 6'h00;
        #12;
        chk_all("reset", 6'h01, 32'h0, 6'h00, 6'h00, 1'b0, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            bus.stall       = tv[i].stall;
            bus.redirect    = tv[i].redirect;
            bus.redirect_pc = tv[i].rpc;
            step();
            chk_all($sformatf("vec%0d", i), tv[i].e_ra, tv[i].e_inst, tv[i].e_pc,
                    tv[i].e_npc, tv[i].e_vld, tv[i].e_cnt);
        end

        // Asynchronous reset while stalled at pc 0D, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst_mid_stall", 6'h01, 32'h0, 6'h00, 6'h00, 1'b0, 16'd0);
        bus.stall = 1'b0;
        step();
        chk_all("arst_held", 6'h01, 32'h0, 6'h00, 6'h00, 1'b0, 16'd0);
        rst_n = 1'b1;

        // Jump word at 0F.
        bus.redirect = 1'b1;
        bus.redirect_pc = 6'h0F;
        step();
        chk_all("jmp_redirect", 6'h0F, 32'h0, 6'h00, 6'h00, 1'b0, 16'd0);
        bus.redirect = 1'b0;
        step();
        chk_all("jmp_fetch", JMP_NEXT, 32'h48000001, 6'h0F, 6'h10, 1'b1, 16'd1);
`ifdef IF_JUMP_PREDECODE_EN
        step();
        chk_all("jmp_target", 6'h02, 32'h14001021, 6'h01, 6'h02, 1'b1, 16'd2);
`else
        bus.redirect = 1'b1;
        bus.redirect_pc = 6'h01;
        step();
        chk_all("jmp_late_redirect", 6'h01, 32'h0, 6'h00, 6'h00, 1'b0, 16'd1);
        bus.redirect = 1'b0;
`endif

        // Fetch counter saturation.
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        chk("cnt_fffe", 32'(bus.fetch_cnt), 32'h0000FFFE);
        step();
        chk("cnt_ffff", 32'(bus.fetch_cnt), 32'h0000FFFF);
        step();
        chk("cnt_sat_hold", 32'(bus.fetch_cnt), 32'h0000FFFF);
        chk("cnt_sat_valid", 32'(bus.if_id_valid), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
